// File: rtl/uart_tx_arb.sv
// uart_tx_arb: packet-granular round-robin arbiter feeding one uart_tx byte
// stream from NUM_REQ requesters. A grant is held until the grantee's last
// byte is accepted, so packets never interleave. One registered output byte
// decouples the transmitter. A watchdog revokes a grant whose owner stalls
// mid-packet for TIMEOUT_CYCLES cycles.
//
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   req_valid    per-requester byte valid
//   req_data     per-requester byte, requester i on [8i+7:8i]
//   req_last     per-requester end-of-packet, qualified by req_valid
//   req_ready    per-requester byte accept (only the grantee, only in LOCK)
//   utx_valid    byte valid to uart_tx
//   utx_data     byte to uart_tx
//   utx_ready    uart_tx accept
//   grant_id     current or most recent grantee
//   busy         high while a grant is held
//   timeout      one-cycle pulse when the watchdog revokes a grant
module uart_tx_arb #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [8*NUM_REQ-1:0]       req_data,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       utx_valid,
  output logic [7:0]                 utx_data,
  input  logic                       utx_ready,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy,
  output logic                       timeout
);

  localparam int DATA_W = 8;
  localparam int IDX_W  = $clog2(NUM_REQ);
  localparam int WD_W   = $clog2(TIMEOUT_CYCLES);

  typedef enum logic {IDLE, LOCK} state_t;

  state_t             state;
  state_t             state_nx;
  logic [IDX_W-1:0]   rr_ptr;
  logic [WD_W-1:0]    wd_cnt;
  logic [DATA_W-1:0]  req_byte [NUM_REQ];
  logic [DATA_W-1:0]  data_g;
  logic               valid_g;
  logic               last_g;
  logic               ready_g;
  logic               accept;
  logic               wd_expire;
  logic               pkt_done;
  logic [IDX_W-1:0]   next_ptr;

  // First requester with valid set, searching upward from ptr with wrap.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] v,
                                               input logic [IDX_W-1:0]   ptr);
    logic [IDX_W-1:0] pick;
    logic [IDX_W:0]   sum;
    logic             found;
    pick  = ptr;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, ptr} + (IDX_W+1)'(k);
      if (sum >= (IDX_W+1)'(NUM_REQ)) sum = sum - (IDX_W+1)'(NUM_REQ);
      if (!found && v[sum[IDX_W-1:0]]) begin
        pick  = sum[IDX_W-1:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) req_byte[i] = req_data[8*i +: 8];
  end

  assign data_g    = req_byte[grant_id];
  assign valid_g   = req_valid[grant_id];
  assign last_g    = req_last[grant_id];
  assign ready_g   = (state == LOCK) && (!utx_valid || utx_ready);
  assign accept    = valid_g && ready_g;
  assign pkt_done  = accept && last_g;
  assign wd_expire = (state == LOCK) && !valid_g && (wd_cnt == WD_W'(TIMEOUT_CYCLES-1));
  assign next_ptr  = (grant_id == IDX_W'(NUM_REQ-1)) ? '0 : grant_id + IDX_W'(1);
  assign busy      = (state == LOCK);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (|req_valid)           state_nx = LOCK;
      LOCK:    if (pkt_done || wd_expire) state_nx = IDLE;
      default:                           state_nx = IDLE;
    endcase
  end

  always_comb begin
    req_ready           = '0;
    req_ready[grant_id] = ready_g;
  end

  // Grant / watchdog / output byte register
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_id  <= '0;
      rr_ptr    <= '0;
      wd_cnt    <= '0;
      timeout   <= 1'b0;
      utx_valid <= 1'b0;
      utx_data  <= '0;
    end else begin
      timeout <= wd_expire;
      if (state == IDLE) begin
        if (|req_valid) begin
          grant_id <= rr_pick(req_valid, rr_ptr);
          wd_cnt   <= '0;
        end
      end else begin
        if (valid_g || wd_expire) wd_cnt <= '0;
        else                      wd_cnt <= wd_cnt + WD_W'(1);
        if (pkt_done || wd_expire) rr_ptr <= next_ptr;
      end
      // A load in the same cycle as a drain keeps utx_valid high.
      if (accept) begin
        utx_valid <= 1'b1;
        utx_data  <= data_g;
      end else if (utx_ready) begin
        utx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arb.sv
// tb_uart_tx_arb: directed and randomized bench for uart_tx_arb. Traffic runs
// are checked against a packet-level round-robin model of the expected byte
// stream and grant order.
module tb_uart_tx_arb;
  localparam int NR = 4;
  localparam int TO = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NR-1:0]   req_valid = '0;
  logic [8*NR-1:0] req_data  = '0;
  logic [NR-1:0]   req_last  = '0;
  logic [NR-1:0]   req_ready;
  logic            utx_valid;
  logic [7:0]      utx_data;
  logic            utx_ready = 1'b1;
  logic [1:0]      grant_id;
  logic            busy;
  logic            timeout;

  int n_checks = 0;
  int n_err    = 0;

  logic [7:0] dmem [NR][64];
  logic       lmem [NR][64];
  int         nb [NR];
  int         rd [NR];
  bit         mid [NR];
  int         gap_run [NR];
  int         pkt_len [NR][8];
  int         npkt [NR];
  logic [7:0] exp_q [$];
  int         exp_g [$];

  uart_tx_arb #(.NUM_REQ(NR), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .utx_valid(utx_valid),
    .utx_data(utx_data), .utx_ready(utx_ready), .grant_id(grant_id),
    .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int r, input logic v, input logic [7:0] d, input logic l);
    req_valid[r]      = v;
    req_data[8*r +: 8] = d;
    req_last[r]       = l;
  endtask

  task automatic do_reset();
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    utx_ready = 1'b1;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  task automatic clear_pkts();
    for (int r = 0; r < NR; r++) begin
      npkt[r] = 0; nb[r] = 0; rd[r] = 0; mid[r] = 1'b0; gap_run[r] = 0;
    end
  endtask

  task automatic add_pkt(input int r, input int len, input bit rnd, input logic [7:0] val);
    for (int i = 0; i < len; i++) begin
      dmem[r][nb[r]] = rnd ? 8'($urandom) : val;
      lmem[r][nb[r]] = (i == len - 1);
      nb[r]++;
    end
    pkt_len[r][npkt[r]] = len;
    npkt[r]++;
  endtask

  // Packet-level round robin: from the pointer, the first requester with a
  // packet left sends its whole packet, then the pointer moves past it.
  task automatic build_model();
    int pi [NR];
    int off [NR];
    int ptr;
    int win;
    bit any;
    exp_q.delete();
    exp_g.delete();
    ptr = 0;
    for (int r = 0; r < NR; r++) begin pi[r] = 0; off[r] = 0; end
    for (int guard = 0; guard < 64; guard++) begin
      any = 1'b0;
      win = 0;
      for (int k = 0; k < NR; k++) begin
        int r;
        r = (ptr + k) % NR;
        if (!any && pi[r] < npkt[r]) begin any = 1'b1; win = r; end
      end
      if (!any) break;
      exp_g.push_back(win);
      for (int i = 0; i < pkt_len[win][pi[win]]; i++)
        exp_q.push_back(dmem[win][off[win] + i]);
      off[win] += pkt_len[win][pi[win]];
      pi[win]++;
      ptr = (win + 1) % NR;
    end
  endtask

  // mode 0: utx_ready always 1; 1: random; 2: held low for cycles 4..13.
  task automatic run_traffic(input int mode, input bit gaps, input int budget, input string tag);
    logic [7:0]    held;
    logic [NR-1:0] gmask;
    bit            stall;
    bit            prev_busy;
    bit            done;
    bit            v;
    int            tocount;
    prev_busy = 1'b0;
    done      = 1'b0;
    tocount   = 0;
    build_model();
    for (int c = 0; c < budget; c++) begin
      case (mode)
        0:       utx_ready = 1'b1;
        1:       utx_ready = ($urandom_range(2) != 0);
        default: utx_ready = !(c >= 4 && c < 14);
      endcase
      for (int r = 0; r < NR; r++) begin
        if (rd[r] < nb[r]) begin
          v = 1'b1;
          if (gaps && mid[r] && gap_run[r] < 4 && $urandom_range(2) == 0) v = 1'b0;
          gap_run[r] = v ? 0 : gap_run[r] + 1;
          set_req(r, v, dmem[r][rd[r]], lmem[r][rd[r]]);
        end else begin
          set_req(r, 1'b0, 8'($urandom), 1'($urandom_range(1)));
        end
      end
      #1;
      gmask = '0;
      if (busy) gmask[grant_id] = 1'b1;
      chk({tag, "_ready_grantee"}, 32'(req_ready & ~gmask), 32'd0);
      for (int r = 0; r < NR; r++) begin
        if (req_valid[r] && req_ready[r]) begin
          mid[r] = !req_last[r];
          rd[r]++;
        end
      end
      if (utx_valid && utx_ready) begin
        if (exp_q.size() == 0) chk({tag, "_extra_byte"}, 32'(utx_data), 32'hFFFF_FFFF);
        else                   chk({tag, "_byte"}, 32'(utx_data), 32'(exp_q.pop_front()));
      end
      stall = utx_valid && !utx_ready;
      held  = utx_data;
      if (stall) chk({tag, "_stall_ready"}, 32'(req_ready), 32'd0);
      cyc();
      if (timeout) tocount++;
      if (stall) begin
        chk({tag, "_stall_valid"}, 32'(utx_valid), 32'd1);
        chk({tag, "_stall_data"}, 32'(utx_data), 32'(held));
      end
      if (busy && !prev_busy) begin
        if (exp_g.size() == 0) chk({tag, "_extra_grant"}, 32'(grant_id), 32'hFFFF_FFFF);
        else                   chk({tag, "_grant"}, 32'(grant_id), 32'(exp_g.pop_front()));
      end
      prev_busy = busy;
      done = (exp_q.size() == 0) && !utx_valid && !busy;
      for (int r = 0; r < NR; r++) if (rd[r] != nb[r]) done = 1'b0;
      if (done) break;
    end
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_timeouts"}, 32'(tocount), 32'd0);
    chk({tag, "_grants_left"}, 32'(exp_g.size()), 32'd0);
    req_valid = '0;
  endtask

  initial begin
    // Reset state
    cyc();
    cyc();
    chk("rst_utx_valid", 32'(utx_valid), 32'd0);
    chk("rst_utx_data", 32'(utx_data), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_grant", 32'(grant_id), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    rst = 1'b0;

    // Single packet 0x48 0x49 0x0A from req0
    set_req(0, 1'b1, 8'h48, 1'b0);
    #1;
    chk("t1_idle_ready", 32'(req_ready), 32'd0);
    cyc();
    chk("t1_grant", 32'(grant_id), 32'd0);
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_ready", 32'(req_ready), 32'b0001);
    chk("t1_uv_c1", 32'(utx_valid), 32'd0);
    cyc();
    chk("t1_uv_c2", 32'(utx_valid), 32'd1);
    chk("t1_d0", 32'(utx_data), 32'h48);
    set_req(0, 1'b1, 8'h49, 1'b0);
    cyc();
    chk("t1_d1", 32'(utx_data), 32'h49);
    set_req(0, 1'b1, 8'h0A, 1'b1);
    cyc();
    chk("t1_d2", 32'(utx_data), 32'h0A);
    chk("t1_busy_end", 32'(busy), 32'd0);
    set_req(0, 1'b0, 8'h00, 1'b0);
    cyc();
    chk("t1_drain", 32'(utx_valid), 32'd0);
    // rr_ptr is now 1: req1 wins over req0, then req0 after the bubble
    set_req(0, 1'b1, 8'hC0, 1'b1);
    set_req(1, 1'b1, 8'hC1, 1'b1);
    cyc();
    chk("t1_ptr_grant", 32'(grant_id), 32'd1);
    chk("t1_ptr_ready", 32'(req_ready), 32'b0010);
    cyc();
    chk("t1_single_busy", 32'(busy), 32'd0);
    chk("t1_single_data", 32'(utx_data), 32'hC1);
    set_req(1, 1'b0, 8'h00, 1'b0);
    cyc();
    chk("t1_next_grant", 32'(grant_id), 32'd0);
    chk("t1_next_busy", 32'(busy), 32'd1);
    cyc();
    chk("t1_next_data", 32'(utx_data), 32'hC0);
    set_req(0, 1'b0, 8'h00, 1'b0);
    cyc();

    // Contention: req1 and req3, two bytes each
    do_reset();
    clear_pkts();
    add_pkt(1, 2, 1'b1, 8'h00);
    add_pkt(3, 2, 1'b1, 8'h00);
    run_traffic(0, 1'b0, 200, "cont");

    // Backpressure: 10 stalled cycles mid-packet
    do_reset();
    clear_pkts();
    add_pkt(0, 6, 1'b1, 8'h00);
    run_traffic(2, 1'b0, 200, "bp");

    // Fairness and pointer wrap: 1-byte packets 0xA0+i
    do_reset();
    clear_pkts();
    for (int p = 0; p < 3; p++)
      for (int r = 0; r < NR; r++) add_pkt(r, 1, 1'b0, 8'(8'hA0 + r));
    run_traffic(0, 1'b0, 200, "fair");

    // Random traffic with mid-packet gaps and random backpressure
    for (int t = 0; t < 3; t++) begin
      do_reset();
      clear_pkts();
      for (int r = 0; r < NR; r++) begin
        int n;
        n = $urandom_range(1, 4);
        for (int p = 0; p < n; p++) add_pkt(r, $urandom_range(1, 5), 1'b1, 8'h00);
      end
      run_traffic(1, 1'b1, 2000, "rand");
    end

    // Watchdog: req2 stalls after one byte, req0 waits
    do_reset();
    set_req(2, 1'b1, 8'h55, 1'b0);
    cyc();
    chk("to_grant", 32'(grant_id), 32'd2);
    cyc();
    chk("to_byte", 32'(utx_data), 32'h55);
    set_req(2, 1'b0, 8'h00, 1'b0);
    set_req(0, 1'b1, 8'h66, 1'b1);
    for (int k = 1; k < TO; k++) begin
      cyc();
      chk("to_early", 32'(timeout), 32'd0);
      chk("to_hold_busy", 32'(busy), 32'd1);
      chk("to_wait_ready", 32'(req_ready[0]), 32'd0);
    end
    cyc();
    chk("to_pulse", 32'(timeout), 32'd1);
    chk("to_busy", 32'(busy), 32'd0);
    cyc();
    chk("to_pulse_end", 32'(timeout), 32'd0);
    chk("to_regrant", 32'(grant_id), 32'd0);
    chk("to_regrant_busy", 32'(busy), 32'd1);
    cyc();
    chk("to_regrant_data", 32'(utx_data), 32'h66);
    set_req(0, 1'b0, 8'h00, 1'b0);
    cyc();

    // Reset mid-packet with a byte in the output register
    do_reset();
    set_req(0, 1'b1, 8'h11, 1'b0);
    cyc();
    cyc();
    chk("mr_uv_before", 32'(utx_valid), 32'd1);
    set_req(0, 1'b1, 8'h22, 1'b0);
    rst = 1'b1;
    cyc();
    chk("mr_uv", 32'(utx_valid), 32'd0);
    chk("mr_ud", 32'(utx_data), 32'd0);
    chk("mr_ready", 32'(req_ready), 32'd0);
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_grant", 32'(grant_id), 32'd0);
    rst = 1'b0;
    set_req(0, 1'b0, 8'h00, 1'b0);
    set_req(2, 1'b1, 8'h33, 1'b1);
    cyc();
    chk("mr_next_grant", 32'(grant_id), 32'd2);
    chk("mr_next_ready", 32'(req_ready), 32'b0100);
    cyc();
    chk("mr_next_data", 32'(utx_data), 32'h33);
    chk("mr_next_uv", 32'(utx_valid), 32'd1);
    chk("mr_next_busy", 32'(busy), 32'd0);
    set_req(2, 1'b0, 8'h00, 1'b0);
    cyc();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/uart_tx_arb.md
Name: uart_tx_arb

Overview:
- Packet-granular round-robin arbiter that shares one UART transmitter byte stream among NUM_REQ requesters, e.g. a demo echo path, a status reporter and a debug dumper.
- Sits between the requesters and the uart_tx valid/ready byte input.
- Holds a grant until the granted requester's last byte is accepted, so packets never interleave.
- A registered output stage decouples the transmitter; a watchdog releases a stalled grant.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- TIMEOUT_CYCLES, 1024, consecutive cycles the granted requester may hold req_valid low mid-packet before the grant is revoked.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester byte valid.
- req_data  in  8*NUM_REQ  per-requester byte; requester i uses bits [8i+7:8i].
- req_last  in  NUM_REQ  per-requester end-of-packet marker, qualified by req_valid.
- req_ready  out  NUM_REQ  per-requester byte accept.
- utx_valid  out  1  byte valid to uart_tx.
- utx_data  out  8  byte to uart_tx.
- utx_ready  in  1  uart_tx accept.
- grant_id  out  $clog2(NUM_REQ)  index of the current or most recent grantee.
- busy  out  1  high while in LOCK.
- timeout  out  1  one-cycle pulse when a grant is revoked by the watchdog.

Behaviour:
- One clock; synchronous, active-high reset.
- Reset values: utx_valid=0, utx_data=0, req_ready=0, grant_id=0, busy=0, timeout=0, rr_ptr=0, wd_cnt=0, state=IDLE. Reset mid-packet discards any byte held in the output register.
- State machine: IDLE, LOCK.
- IDLE:
  - req_ready all 0.
  - If any req_valid is high, select the first set bit searching from rr_ptr upward, wrapping past NUM_REQ-1 to 0.
  - Register grant_id = winner, busy=1, wd_cnt=0; go to LOCK next cycle.
  - With no request, stay in IDLE.
- LOCK:
  - req_ready[grant_id] = (!utx_valid || utx_ready); this path is combinational. All other req_ready bits are 0.
  - Accept = req_valid[grant_id] && req_ready[grant_id]. On accept, load utx_data <= req_data[grant_id] and set utx_valid=1.
  - On accept with req_last=1: next state IDLE, busy=0, rr_ptr = (grant_id+1) mod NUM_REQ.
- Output register:
  - utx_valid, once set, holds with utx_data stable until utx_ready=1.
  - utx_valid clears on utx_ready unless a new accept occurs in the same cycle; simultaneous drain and load gives full throughput.
  - The output register keeps draining in IDLE.
- Latency:
  - req_valid rises in IDLE at cycle 0; grant and req_ready appear at cycle 1; the byte is accepted at cycle 1; utx_valid=1 at cycle 2.
  - One IDLE bubble cycle follows every packet.
- Watchdog:
  - In LOCK, wd_cnt increments each cycle req_valid[grant_id]=0 and resets to 0 on any cycle it is 1.
  - When wd_cnt reaches TIMEOUT_CYCLES-1 with req_valid still low:
    - pulse timeout for 1 cycle;
    - return to IDLE with busy=0;
    - advance rr_ptr past grant_id;
    - leave the byte in the output register to drain normally.
  - The watchdog is inactive in IDLE.
- Boundary conditions:
  - A single-byte packet (valid and last in the first grant cycle) is legal: LOCK lasts exactly 1 cycle.
  - A requester dropping req_valid mid-packet is legal up to the timeout.
  - The grant is decided only in IDLE; requests arriving during LOCK wait.
  - Fairness: a requester with a pending request is granted within NUM_REQ-1 packets.
  - req_data and req_last of non-granted requesters are ignored.
  - rr_ptr wraps from NUM_REQ-1 to 0.

Test Plan:
- Single packet: req0 sends 0x48,0x49,0x0A (last on 0x0A) with utx_ready=1 -> utx_data sequence 0x48,0x49,0x0A, first utx_valid 2 cycles after req_valid; busy falls after 0x0A; rr_ptr=1.
- Contention: req1 and req3 assert simultaneously from reset, each sending a 2-byte packet -> req1's packet fully first, then req3's; no interleaving; grant_id 1 then 3.
- Backpressure: utx_ready held 0 for 10 cycles mid-packet -> utx_data stable; req_ready[g]=0 while utx_valid=1; no byte lost or duplicated; byte order preserved.
- Fairness and wrap: all 4 requesters continuously send 1-byte packets 0xA0+i -> grant order 0,1,2,3,0,1; rr_ptr wraps 3->0.
- Timeout: TIMEOUT_CYCLES=16; req2 sends one byte without last, then drops valid -> timeout pulses 16 cycles after the drop; busy=0; pending req0 is granted next.
- Reset mid-packet: rst=1 for 1 cycle during req0's second byte with utx_valid=1 -> next cycle utx_valid=0, all req_ready=0, busy=0, grant_id=0; the following request is granted normally.
